ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/ifu.sv | 125 ++++++++++++
 tb/tb_ifu.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared SoC fetch definitions: word width, IFU state and buffer entry.
// Imported by the fetch unit and its instruction buffer.
package ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, inst} pairs between memory and decoder.
// Push and pop may coincide even when full; flush empties it at once.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty head reads as zero so nothing stale leaks to the decoder.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues word fetches under a credit limit and
// buffers in-order responses with their pc for the decoder.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  ifu_state_e state;
  ifu_state_e state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [IW-1:0]   inflight;
  logic            req_fire;
  logic            redir_take;
  logic            push;
  logic            full;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (halt) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Credit: requests in flight plus buffered entries never exceed depth.
  assign inflight = IW'(outstanding) + IW'(fifo_count);

  assign redir_take = (state == RUN) && redirect && !halt;

  assign imem_req_valid = (state == RUN) && !redirect && !halt &&
                          !full && (inflight < IW'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  assign push = imem_resp_valid && (drop_cnt == '0) && !redir_take;

  assign push_data = '{pc: resp_pc, inst: imem_resp_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redir_take) begin
        pc       <= redirect_pc & ~32'h3;
        resp_pc  <= redirect_pc & ~32'h3;
        drop_cnt <= out_nxt;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
        if (imem_resp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (inst_ready),
    .flush    (redir_take),
    .head     (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
  );

  assign inst_valid = !empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed cycle table, corner sequences, and random
// traffic against a queue-based model of memory and decoder buffer.
module tb_ifu;
  import ifu_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  always #5 clock = ~clock;

  ifu #(
    .RESET_PC  (32'h8000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  typedef struct {
    logic [31:0] addr;
    bit          live;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit          iready;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  mreq_t       memq[$];
  ent_t        mbuf[$];
  logic [31:0] exp_pc;
  bit          run_m;
  bit          halted_m;
  bit          resp_en;
  bit          cur_valid;
  bit          cur_live;
  logic [31:0] cur_addr;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_inst_valid;
  logic [31:0] s_inst_pc;
  logic [31:0] s_inst;
  bit          s_fire;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    memq.delete();
    mbuf.delete();
    run_m = 0;
    halted_m = 0;
    exp_pc = 32'h8000_0000;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    reset = 1'b1;
  endtask

  // One clock: drive memory response, sample at +1, check, advance model.
  task automatic tick();
    mreq_t m;
    int    pend;
    bit    ok;
    bit    redir_eff;
    cur_valid = 0;
    cur_live = 0;
    cur_addr = '0;
    if (resp_en && memq.size() > 0) begin
      m = memq.pop_front();
      cur_valid = 1;
      cur_addr = m.addr;
      cur_live = m.live;
    end
    imem_resp_valid = cur_valid;
    imem_resp_data = cur_valid ? mdata(cur_addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc = inst_pc;
    s_inst = inst;
    s_fire = s_req_valid && imem_req_ready;
    pend = memq.size() + int'(cur_valid);
    chk("m_inst_valid", 32'(s_inst_valid), 32'(mbuf.size() != 0));
    if (mbuf.size() != 0) begin
      chk("m_inst_pc", s_inst_pc, mbuf[0].pc);
      chk("m_inst", s_inst, mbuf[0].inst);
    end
    if (s_req_valid) begin
      ok = run_m && !halted_m && !redirect && !halt &&
           (pend + mbuf.size() < DEPTH);
      chk("m_req_legal", 32'(ok), 32'd1);
      chk("m_req_addr", s_req_addr, exp_pc);
    end
    if (mbuf.size() != 0 && inst_ready) void'(mbuf.pop_front());
    redir_eff = run_m && !halted_m && redirect && !halt;
    if (redir_eff) begin
      mbuf.delete();
      foreach (memq[i]) memq[i].live = 0;
      cur_live = 0;
      exp_pc = redirect_pc & ~32'h3;
    end
    if (run_m && !halted_m && halt) halted_m = 1;
    if (cur_valid && cur_live)
      mbuf.push_back('{pc: cur_addr, inst: mdata(cur_addr)});
    if (s_fire) begin
      memq.push_back('{addr: s_req_addr, live: 1'b1});
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clock);
    run_m = 1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    bit          found = 0;
    logic [31:0] a = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_fire) begin
        found = 1;
        a = s_req_addr;
      end
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    chk(name, a, exp);
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp);
    bit          found = 0;
    logic [31:0] p = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_inst_valid) begin
        found = 1;
        p = s_inst_pc;
      end
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    chk(name, p, exp);
  endtask

  vec_t tbl[11];

  initial begin
    int          nfire;
    bit          got;
    logic [31:0] gpc;

    tbl[0]  = '{0, 0, 32'h0,         0, 32'h0};
    tbl[1]  = '{0, 1, 32'h8000_0000, 0, 32'h0};
    tbl[2]  = '{0, 1, 32'h8000_0004, 0, 32'h0};
    tbl[3]  = '{0, 0, 32'h0,         1, 32'h8000_0000};
    tbl[4]  = '{0, 0, 32'h0,         1, 32'h8000_0000};
    tbl[5]  = '{0, 0, 32'h0,         1, 32'h8000_0000};
    tbl[6]  = '{1, 0, 32'h0,         1, 32'h8000_0000};
    tbl[7]  = '{1, 1, 32'h8000_0008, 1, 32'h8000_0004};
    tbl[8]  = '{1, 1, 32'h8000_000C, 0, 32'h0};
    tbl[9]  = '{1, 0, 32'h0,         1, 32'h8000_0008};
    tbl[10] = '{1, 1, 32'h8000_0010, 1, 32'h8000_000C};

    // Startup, backpressure and in-order drain
    do_reset();
    imem_req_ready = 1;
    resp_en = 1;
    for (int i = 0; i < 11; i++) begin
      inst_ready = tbl[i].iready;
      tick();
      chk($sformatf("t%0d_req_valid", i), 32'(s_req_valid),
          32'(tbl[i].rv));
      if (tbl[i].rv)
        chk($sformatf("t%0d_req_addr", i), s_req_addr, tbl[i].addr);
      chk($sformatf("t%0d_inst_valid", i), 32'(s_inst_valid),
          32'(tbl[i].iv));
      if (tbl[i].iv)
        chk($sformatf("t%0d_inst_pc", i), s_inst_pc, tbl[i].ipc);
    end

    // Redirect with two requests outstanding
    do_reset();
    imem_req_ready = 1;
    inst_ready = 1;
    resp_en = 0;
    tick();
    tick();
    tick();
    redirect = 1;
    redirect_pc = 32'h0000_1003;
    tick();
    chk("rd_req_valid", 32'(s_req_valid), 32'd0);
    redirect = 0;
    resp_en = 1;
    wait_req("rd_next_req", 32'h0000_1000);
    wait_inst("rd_first_inst", 32'h0000_1000);

    // Response arriving in the redirect cycle
    do_reset();
    imem_req_ready = 1;
    inst_ready = 1;
    resp_en = 0;
    tick();
    tick();
    tick();
    resp_en = 1;
    redirect = 1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect = 0;
    wait_inst("same_cyc_inst", 32'h0000_2000);

    // Halt with one outstanding, later redirect ignored
    do_reset();
    imem_req_ready = 1;
    inst_ready = 1;
    resp_en = 0;
    tick();
    tick();
    halt = 1;
    tick();
    chk("halt_req_valid", 32'(s_req_valid), 32'd0);
    halt = 0;
    redirect = 1;
    redirect_pc = 32'h0000_3000;
    resp_en = 1;
    tick();
    redirect = 0;
    nfire = 0;
    got = 0;
    gpc = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_req_valid) nfire++;
      if (s_inst_valid && !got) begin
        got = 1;
        gpc = s_inst_pc;
      end
    end
    chk("halt_no_req", 32'(nfire), 32'd0);
    chk("halt_deliv", 32'(got), 32'd1);
    chk("halt_deliv_pc", gpc, 32'h8000_0000);

    // Address wrap at the top of memory
    do_reset();
    imem_req_ready = 1;
    inst_ready = 1;
    resp_en = 1;
    tick();
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 0;
    wait_req("wrap_req0", 32'hFFFF_FFFC);
    wait_req("wrap_req1", 32'h0000_0000);

    // Random traffic, with reset landing mid-transaction between runs
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        resp_en = ($urandom_range(0, 2) != 0);
        inst_ready = ($urandom_range(0, 2) != 0);
        redirect = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom;
        halt = ($urandom_range(0, 299) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
